// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage between EX/MEM and MEM/WB.
// Runs one req/ack data-bus transfer per load/store and stalls until done.
package mem_lsu_pkg;
  localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
  localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [7:0] EXE_ADDU_OP = 8'b00100001;
  localparam logic [7:0] EXE_LB_OP   = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP  = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP   = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP  = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP   = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP   = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP   = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP   = 8'b11101011;
endpackage

module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        align_err_o,
  output logic        bus_err_o,
  output logic [31:0] badaddr_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  op;
  logic [1:0]  off;
  logic [7:0]  cnt;
  logic        err;
  logic [31:0] result;

  logic        is_mem;
  logic        is_store;
  logic        misal;
  logic [3:0]  sel_n;
  logic [31:0] wdat_n;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic [31:0] lfmt;

  always_comb begin
    is_mem   = 1'b1;
    is_store = 1'b0;
    misal    = 1'b0;
    sel_n    = 4'b1111;
    wdat_n   = reg2_i;
    unique case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        is_store = aluop_i == EXE_SB_OP;
        wdat_n   = {4{reg2_i[7:0]}};
        case (mem_addr_i[1:0])
          2'b00:   sel_n = 4'b1000;
          2'b01:   sel_n = 4'b0100;
          2'b10:   sel_n = 4'b0010;
          default: sel_n = 4'b0001;
        endcase
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        is_store = aluop_i == EXE_SH_OP;
        misal    = mem_addr_i[0];
        wdat_n   = {2{reg2_i[15:0]}};
        sel_n    = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      end
      EXE_LW_OP, EXE_SW_OP: begin
        is_store = aluop_i == EXE_SW_OP;
        misal    = mem_addr_i[1:0] != 2'b00;
      end
      default: is_mem = 1'b0;
    endcase
  end

  // Big-endian lane pick: offset 0 is the most significant byte.
  always_comb begin
    case (off)
      2'b00:   lbyte = dbus_rdata_i[31:24];
      2'b01:   lbyte = dbus_rdata_i[23:16];
      2'b10:   lbyte = dbus_rdata_i[15:8];
      default: lbyte = dbus_rdata_i[7:0];
    endcase
    lhalf = off[1] ? dbus_rdata_i[15:0] : dbus_rdata_i[31:16];
    case (op)
      EXE_LB_OP:  lfmt = {{24{lbyte[7]}}, lbyte};
      EXE_LBU_OP: lfmt = {24'd0, lbyte};
      EXE_LH_OP:  lfmt = {{16{lhalf[15]}}, lhalf};
      EXE_LHU_OP: lfmt = {16'd0, lhalf};
      EXE_LW_OP:  lfmt = dbus_rdata_i;
      default:    lfmt = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      op           <= 8'd0;
      off          <= 2'd0;
      cnt          <= 8'd0;
      err          <= 1'b0;
      result       <= 32'd0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= 32'd0;
      dbus_sel_o   <= 4'd0;
      dbus_wdata_o <= 32'd0;
    end else begin
      case (state)
        IDLE: if (is_mem && !misal) begin
          state        <= REQ;
          op           <= aluop_i;
          off          <= mem_addr_i[1:0];
          cnt          <= 8'd0;
          err          <= 1'b0;
          result       <= 32'd0;
          dbus_req_o   <= 1'b1;
          dbus_we_o    <= is_store;
          dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
          dbus_sel_o   <= sel_n;
          dbus_wdata_o <= wdat_n;
        end
        REQ: begin
          if (dbus_ack_i) begin
            state      <= DONE;
            result     <= lfmt;
            dbus_req_o <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state      <= DONE;
            err        <= 1'b1;
            dbus_req_o <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          err   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wd_o        = 5'd0;
    wreg_o      = 1'b0;
    wdata_o     = 32'd0;
    stallreq_o  = 1'b0;
    align_err_o = 1'b0;
    bus_err_o   = 1'b0;
    badaddr_o   = 32'd0;
    if (rst) begin
      wd_o = wd_i;
      case (state)
        IDLE: begin
          if (!is_mem) begin
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end else if (misal) begin
            align_err_o = 1'b1;
            badaddr_o   = mem_addr_i;
          end else begin
            stallreq_o = 1'b1;
          end
        end
        REQ: stallreq_o = 1'b1;
        default: begin
          if (err) begin
            bus_err_o = 1'b1;
            badaddr_o = mem_addr_i;
          end else if (!dbus_we_o) begin
            wreg_o  = wreg_i;
            wdata_o = result;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage; sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Passes non-memory results through unchanged.
- For load/store ops, runs a req/ack transaction on the data bus, formats load data (big-endian, sign/zero extension), and holds the pipeline via stallreq_o until the access completes.
- Detects misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 255, maximum cycles in REQ waiting for dbus_ack before aborting (1..255; counter is 8 bits)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
wd_i  in  5  destination register from EX/MEM
wreg_i  in  1  write-enable from EX/MEM
wdata_i  in  32  ALU result from EX/MEM
aluop_i  in  8  operation code (defines.v EXE_*_OP)
mem_addr_i  in  32  effective address
reg2_i  in  32  store data source
wd_o  out  5  destination register to MEM/WB
wreg_o  out  1  write-enable to MEM/WB
wdata_o  out  32  result to MEM/WB
stallreq_o  out  1  stall request to ctrl (ctrl drives stall=6'b011111)
dbus_req_o  out  1  bus request, registered
dbus_we_o  out  1  1=store, registered
dbus_addr_o  out  32  word address {addr[31:2],2'b00}, registered
dbus_sel_o  out  4  byte-lane enables, bit3=bits 31:24, registered
dbus_wdata_o  out  32  store data, registered
dbus_rdata_i  in  32  read data, valid with ack
dbus_ack_i  in  1  transfer complete, one cycle
align_err_o  out  1  misaligned access this cycle
bus_err_o  out  1  timeout abort, one-cycle pulse in DONE
badaddr_o  out  32  faulting address (valid with either error)

Behaviour:
- Reset (rst=0, async): state=IDLE, all registered bus outputs 0, result reg 0, timeout counter 0, error flags 0. While in reset: wd_o=0, wreg_o=0, wdata_o=0, stallreq_o=0. Reset mid-transaction drops dbus_req_o immediately; the transaction is abandoned.
- Memory ops: EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP. Everything else is non-memory.
- IDLE, non-memory op: combinational pass-through wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i; stallreq_o=0.
- IDLE, misaligned memory op:
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - align_err_o=1, badaddr_o=mem_addr_i, wreg_o=0, stallreq_o=0.
  - No bus access; remain in IDLE.
- IDLE, aligned memory op:
  - stallreq_o=1 combinationally; wreg_o=0.
  - At the clock edge, latch bus outputs, clear the counter, and go to REQ.
- Byte lanes (big-endian):
  - SB/LB/LBU: addr[1:0] 00→sel 1000, 01→0100, 10→0010, 11→0001.
  - SH/LH/LHU: addr[1] 0→1100, 1→0011.
  - SW/LW: 1111.
  - Store data: SB={4{reg2[7:0]}}, SH={2{reg2[15:0]}}, SW=reg2.
- REQ:
  - dbus_req_o=1, stallreq_o=1, wreg_o=0. Bus outputs are stable for the whole state.
  - On dbus_ack_i=1: capture the formatted load data into the result reg (stores capture 0), go to DONE, and deassert dbus_req_o at that edge.
  - No ack: counter increments. When counter==TIMEOUT-1 with no ack, set the bus-error flag and go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- Load formatting: LB sign-extends the selected byte, LBU zero-extends it; LH/LHU likewise for the selected halfword; LW takes the word unchanged.
- DONE:
  - stallreq_o=0; wd_o=wd_i.
  - Loads: wreg_o=wreg_i, wdata_o=result reg.
  - Stores: wreg_o=0, wdata_o=0.
  - On bus error: bus_err_o=1, badaddr_o=mem_addr_i, wreg_o=0.
  - Unconditionally return to IDLE next edge; MEM/WB captures at that edge and EX/MEM advances.
- dbus_ack_i outside REQ is ignored.
- Minimum memory-op occupancy is 3 cycles (IDLE, REQ with same-cycle ack, DONE), i.e. 2 stall cycles. Back-to-back memory ops go IDLE→REQ with no extra bubble.
- Error flags are 0 except in the cases stated above.

Test Plan:
- Pass-through: aluop=EXE_OR_OP, wd=5, wreg=1, wdata=32'h1234 → same cycle wd_o=5, wreg_o=1, wdata_o=32'h1234, stallreq_o=0, dbus_req_o stays 0.
- LB sign-extend: addr=32'h101, dbus_rdata=32'h11F2_3344, ack on first REQ cycle → dbus_addr=32'h100, sel=0100, stallreq high 2 cycles, DONE wdata_o=32'hFFFF_FFF2; LBU variant gives 32'h0000_00F2.
- SH: addr=32'h202, reg2=32'hAAAA_BEEF, ack after 3 cycles → dbus_we=1, sel=0011, wdata=32'hBEEF_BEEF, stallreq high 4 cycles, DONE wreg_o=0.
- Misaligned LW: addr=32'h3 → align_err_o=1, badaddr_o=32'h3, no dbus_req, stallreq_o=0, wreg_o=0.
- Timeout: TIMEOUT=4, LW with no ack → dbus_req high exactly 4 cycles, then DONE with bus_err_o=1 for one cycle, wreg_o=0, then IDLE; ack arriving afterwards is ignored.
- Async reset in REQ: rst low mid-cycle → dbus_req_o and stallreq_o drop without waiting for a clock edge; after release, state is IDLE and the next LW starts a fresh transaction.
